pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_TIMEOUT, 16, max consecutive MEMWAIT cycles before abort (legal range 2..255).
REQ-002 SHALL have port: Clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: Rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: id_opcode  input  4  opcode of instruction in ID (inst[17:14]).
REQ-005 SHALL have port: id_rs1  input  3  ID source/dest field inst[13:11].
REQ-006 SHALL have port: id_rs2  input  3  ID source field inst[10:8].
REQ-007 SHALL have port: ex_memRead  input  1  instruction in EX is LW.
REQ-008 SHALL have port: ex_dest  input  3  RF destination of instruction in EX.
REQ-009 SHALL have port: br_taken  input  1  ID branch resolved taken (sel_PC).
REQ-010 SHALL have port: mem_req  input  1  MEM stage data-memory access active (memEnab).
REQ-011 SHALL have port: mem_ready  input  1  data memory completes access this cycle.
REQ-012 SHALL have port: halt_req  input  1  level request to halt fetch.
REQ-013 SHALL have port: step_req  input  1  single-cycle pulse; advance one cycle while halted.
REQ-014 SHALL have outputs, each 1 bit: pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, halted, mem_timeout.

Function
REQ-015 SHALL implement FSM states RUN, MEMWAIT, HALTED, STEP, plus ret_halt flag and 8-bit wait counter.
REQ-016 SHALL compute load_use = ex_memRead & (ex_dest!=0) & ((use1 & ex_dest==id_rs1) | (use2 & ex_dest==id_rs2)).
REQ-017 SHALL set use1 for opcodes 0,2,3,4,8,9,10,11; use2 for opcodes 0,1,2,5,8,9,10,11; both 0 otherwise.
REQ-018 SHALL default (RUN/STEP, no event): pc_en=1, ifid_en=1, exmem_en=1, all flush/bubble=0.
REQ-019 SHALL, in RUN/STEP with mem_req & !mem_ready: freeze (pc_en=ifid_en=exmem_en=0, memwb_bubble=1), next state MEMWAIT, counter<=1, ret_halt<=(state==STEP).
REQ-020 SHALL, else if load_use: pc_en=0, ifid_en=0, idex_bubble=1; br_taken ignored that cycle.
REQ-021 SHALL, else if br_taken: ifid_flush=1 (one bubble), pc_en=ifid_en=1.
REQ-022 SHALL priority: memory wait > load_use > br_taken.
REQ-023 SHALL, in MEMWAIT with mem_ready=0 and counter<WAIT_TIMEOUT: freeze outputs, counter+1.
REQ-024 SHALL, in MEMWAIT with mem_ready=1: produce RUN-rule outputs (REQ-018..022, excluding REQ-019) and exit to HALTED if ret_halt else RUN.
REQ-025 SHALL, in MEMWAIT with mem_ready=0 and counter==WAIT_TIMEOUT: set mem_timeout (sticky), memwb_bubble=1, exmem_en=1, pc_en=ifid_en=1, exit per ret_halt.
REQ-026 SHALL, in RUN with halt_req=1 and no memory wait: apply RUN outputs that cycle, next state HALTED.
REQ-027 SHALL, in HALTED: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1, halted=1 (pipeline drains).
REQ-028 SHALL, in HALTED: step_req=1 -> STEP; else halt_req=0 -> RUN; step_req has priority.
REQ-029 SHALL, in STEP: one cycle of RUN rules, halted=0, then HALTED (or MEMWAIT per REQ-019).
REQ-030 SHALL treat step_req in RUN/MEMWAIT/STEP as no-op; halt_req in MEMWAIT is deferred until exit.
REQ-031 SHALL drive all outputs combinationally from state and current inputs (no added latency).

Reset
REQ-032 SHALL, while Rst=1: next state RUN, counter 0, ret_halt 0, mem_timeout 0.
REQ-033 SHALL, while Rst=1: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, exmem_en=1, memwb_bubble=1, halted=0.
REQ-034 SHALL abort any MEMWAIT/HALTED/STEP on Rst, first post-reset cycle in RUN.

Verification
REQ-035 SHALL test load-use: ex_memRead=1, ex_dest=3, id_opcode=0, id_rs2=3 -> pc_en=0, ifid_en=0, idex_bubble=1 one cycle; ex_dest=0 -> no stall.
REQ-036 SHALL test stall priority: load_use=1 and br_taken=1 same cycle -> ifid_flush=0, idex_bubble=1; next cycle br_taken=1 only -> ifid_flush=1.
REQ-037 SHALL test memory wait: mem_req=1, mem_ready low 3 cycles then high -> 3 frozen cycles (memwb_bubble=1), release cycle all enables 1.
REQ-038 SHALL test timeout: WAIT_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 on 4th MEMWAIT cycle, stays 1 until Rst.
REQ-039 SHALL test halt/step: halt_req=1 -> halted=1 next cycle; step_req pulse -> exactly one cycle pc_en=1, then halted=1; halt_req=0 -> RUN.
REQ-040 SHALL test reset mid-MEMWAIT: Rst at counter=2 -> REQ-033 outputs, RUN after release, mem_timeout=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = pipeline side driving hazard inputs, slave = controller.
interface pipe_hazard_ctrl_if;
    logic [3:0] id_opcode;
    logic [2:0] id_rs1;
    logic [2:0] id_rs2;
    logic       ex_memRead;
    logic [2:0] ex_dest;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       halt_req;
    logic       step_req;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       exmem_en;
    logic       memwb_bubble;
    logic       halted;
    logic       mem_timeout;

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_memRead, ex_dest,
        output br_taken, mem_req, mem_ready, halt_req, step_req,
        input  pc_en, ifid_en, ifid_flush, idex_bubble,
        input  exmem_en, memwb_bubble, halted, mem_timeout
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_memRead, ex_dest,
        input  br_taken, mem_req, mem_ready, halt_req, step_req,
        output pc_en, ifid_en, ifid_flush, idex_bubble,
        output exmem_en, memwb_bubble, halted, mem_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory wait
// with timeout abort, and halt / single-step debug control.
module pipe_hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Rst,
    pipe_hazard_ctrl_if.slave hif
);
    typedef enum logic [1:0] {RUN, MEMWAIT, HALTED, STEP} state_t;

    localparam logic [7:0] WT = 8'(WAIT_TIMEOUT);

    state_t     state;
    logic [7:0] cnt;
    logic       ret_halt;
    logic       to_q;

    logic use1, use2, load_use;
    logic mem_stall, cnt_done;

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (hif.id_opcode)
            4'd0, 4'd2, 4'd8, 4'd9, 4'd10, 4'd11: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            4'd3, 4'd4: use1 = 1'b1;
            4'd1, 4'd5: use2 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = hif.ex_memRead && (hif.ex_dest != 3'd0) &&
                      ((use1 && hif.ex_dest == hif.id_rs1) ||
                       (use2 && hif.ex_dest == hif.id_rs2));

    assign mem_stall = hif.mem_req && !hif.mem_ready;
    assign cnt_done  = (cnt >= WT);

    logic pc_en, ifid_en, ifid_flush, idex_bubble;
    logic exmem_en, memwb_bubble, halted, to_now;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        to_now       = 1'b0;
        if (Rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            unique case (state)
                RUN, STEP: begin
                    if (mem_stall) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (hif.br_taken) begin
                        ifid_flush = 1'b1;
                    end
                end
                MEMWAIT: begin
                    if (hif.mem_ready) begin
                        if (load_use) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_bubble = 1'b1;
                        end else if (hif.br_taken) begin
                            ifid_flush = 1'b1;
                        end
                    end else if (!cnt_done) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                    end else begin
                        // abort: drop the stuck access, let everything else move
                        memwb_bubble = 1'b1;
                        to_now       = 1'b1;
                    end
                end
                HALTED: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                end
            endcase
        end
    end

    assign hif.pc_en        = pc_en;
    assign hif.ifid_en      = ifid_en;
    assign hif.ifid_flush   = ifid_flush;
    assign hif.idex_bubble  = idex_bubble;
    assign hif.exmem_en     = exmem_en;
    assign hif.memwb_bubble = memwb_bubble;
    assign hif.halted       = halted;
    assign hif.mem_timeout  = !Rst && (to_q || to_now);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= RUN;
            cnt      <= 8'd0;
            ret_halt <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEMWAIT;
                        cnt      <= 8'd1;
                        ret_halt <= 1'b0;
                    end else if (hif.halt_req) begin
                        state <= HALTED;
                    end
                end
                STEP: begin
                    if (mem_stall) begin
                        state    <= MEMWAIT;
                        cnt      <= 8'd1;
                        ret_halt <= 1'b1;
                    end else begin
                        state <= HALTED;
                    end
                end
                MEMWAIT: begin
                    if (hif.mem_ready || cnt_done) begin
                        state <= ret_halt ? HALTED : RUN;
                        cnt   <= 8'd0;
                        if (!hif.mem_ready)
                            to_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HALTED: begin
                    if (hif.step_req)
                        state <= STEP;
                    else if (!hif.halt_req)
                        state <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with WAIT_TIMEOUT=4.
// Outputs packed as {pc,ifid,flush,idex_bub,exmem,memwb_bub,halted,timeout}.
module tb_pipe_hazard_ctrl;
    logic Clk;
    logic Rst;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl #(.WAIT_TIMEOUT(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .hif (hif.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [7:0] O_RUN  = 8'b1100_1000;
    localparam logic [7:0] O_LU   = 8'b0001_1000;
    localparam logic [7:0] O_BR   = 8'b1110_1000;
    localparam logic [7:0] O_FRZ  = 8'b0000_0100;
    localparam logic [7:0] O_RST  = 8'b0011_1100;
    localparam logic [7:0] O_HLT  = 8'b0001_1010;
    localparam logic [7:0] O_TO   = 8'b1100_1101;
    localparam logic [7:0] O_RUNT = 8'b1100_1001;
    localparam logic [7:0] O_FRZT = 8'b0000_0101;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [7:0] outs();
        return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_bubble,
                hif.exmem_en, hif.memwb_bubble, hif.halted, hif.mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // check combinational outputs mid-cycle, then let the edge happen
    task automatic cyc(input string tag, input logic [7:0] exp);
        @(negedge Clk);
        check(tag, outs(), exp);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        hif.id_opcode  = 4'd0;
        hif.id_rs1     = 3'd0;
        hif.id_rs2     = 3'd0;
        hif.ex_memRead = 1'b0;
        hif.ex_dest    = 3'd0;
        hif.br_taken   = 1'b0;
        hif.mem_req    = 1'b0;
        hif.mem_ready  = 1'b0;
        hif.halt_req   = 1'b0;
        hif.step_req   = 1'b0;
    endtask

    task automatic lu(input logic [3:0] op, input logic [2:0] r1,
                      input logic [2:0] r2, input logic [2:0] dst);
        hif.ex_memRead = 1'b1;
        hif.id_opcode  = op;
        hif.id_rs1     = r1;
        hif.id_rs2     = r2;
        hif.ex_dest    = dst;
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        cyc("rst", O_RST);
        Rst = 1'b0;
        cyc("idle", O_RUN);

        lu(4'd0, 3'd5, 3'd3, 3'd3);
        cyc("lu_rs2", O_LU);
        idle();
        cyc("lu_release", O_RUN);
        lu(4'd0, 3'd0, 3'd0, 3'd0);
        cyc("lu_r0", O_RUN);
        lu(4'd12, 3'd3, 3'd3, 3'd3);
        cyc("lu_nouse", O_RUN);
        lu(4'd3, 3'd3, 3'd1, 3'd3);
        cyc("lu_rs1", O_LU);
        lu(4'd1, 3'd3, 3'd1, 3'd3);
        cyc("lu_op1_rs1", O_RUN);

        lu(4'd0, 3'd5, 3'd3, 3'd3);
        hif.br_taken = 1'b1;
        cyc("prio_lu", O_LU);
        hif.ex_memRead = 1'b0;
        cyc("prio_br", O_BR);
        idle();

        hif.mem_req = 1'b1;
        cyc("mw_frz1", O_FRZ);
        cyc("mw_frz2", O_FRZ);
        cyc("mw_frz3", O_FRZ);
        hif.mem_ready = 1'b1;
        cyc("mw_release", O_RUN);
        idle();
        cyc("mw_after", O_RUN);

        hif.mem_req = 1'b1;
        cyc("to_enter", O_FRZ);
        cyc("to_w1", O_FRZ);
        cyc("to_w2", O_FRZ);
        cyc("to_w3", O_FRZ);
        cyc("to_w4", O_TO);
        hif.mem_req = 1'b0;
        cyc("to_sticky", O_RUNT);
        hif.mem_req = 1'b1;
        cyc("to_sticky_frz", O_FRZT);
        idle();
        Rst = 1'b1;
        cyc("to_rst", O_RST);
        Rst = 1'b0;
        cyc("to_cleared", O_RUN);

        hif.step_req = 1'b1;
        cyc("step_in_run", O_RUN);
        hif.step_req = 1'b0;
        hif.halt_req = 1'b1;
        cyc("halt_req", O_RUN);
        cyc("halted", O_HLT);
        cyc("halted_hold", O_HLT);
        hif.step_req = 1'b1;
        cyc("step_req", O_HLT);
        hif.step_req = 1'b0;
        cyc("step", O_RUN);
        cyc("step_done", O_HLT);
        hif.halt_req = 1'b0;
        cyc("unhalt", O_HLT);
        cyc("resumed", O_RUN);

        hif.mem_req = 1'b1;
        cyc("mwr_enter", O_FRZ);
        cyc("mwr_c1", O_FRZ);
        Rst = 1'b1;
        cyc("mwr_rst", O_RST);
        Rst = 1'b0;
        hif.mem_req = 1'b0;
        cyc("mwr_run", O_RUN);
        cyc("mwr_run2", O_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
